// File: rtl/coherence_xbar_n.sv
// N-port coherence crossbar: round-robin request arbitration into a registered directory slice,
// per-destination response/forward routing, invalidation multicast and invalidation-ack counting.
module coherence_xbar_n #(
  parameter int         N_CPU                   = 4,
  parameter int         ADDR_W                  = 32,
  parameter int         BLK_W                   = 128,
  parameter logic [3:0] TYPE_NONE               = 4'h0,
  parameter logic [3:0] TYPE_FORWARD_DATA       = 4'h8,
  parameter logic [3:0] TYPE_FORWARD_DATA_PUT_E = 4'h6,
  parameter logic [3:0] TYPE_FORWARD_DATA_PUT_M = 4'h7,
  localparam int        CPU_W                   = $clog2(N_CPU)
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [N_CPU-1:0]             cpu_req_valid_i,
  output logic [N_CPU-1:0]             cpu_req_ready_o,
  input  logic [4*N_CPU-1:0]           cpu_req_type_i,
  input  logic [BLK_W*N_CPU-1:0]       cpu_req_data_i,
  input  logic [ADDR_W*N_CPU-1:0]      cpu_req_addr_i,
  input  logic [CPU_W*N_CPU-1:0]       cpu_req_dst_i,
  input  logic [N_CPU-1:0]             cpu_inv_ack_i,
  input  logic [CPU_W*N_CPU-1:0]       cpu_inv_ack_dst_i,
  output logic                         dir_req_valid_o,
  input  logic                         dir_req_ready_i,
  output logic [3:0]                   dir_req_type_o,
  output logic [BLK_W-1:0]             dir_req_data_o,
  output logic [ADDR_W-1:0]            dir_req_addr_o,
  output logic [CPU_W-1:0]             dir_req_src_o,
  input  logic                         dir_rsp_valid_i,
  input  logic [CPU_W-1:0]             dir_rsp_dst_i,
  input  logic [3:0]                   dir_rsp_type_i,
  input  logic [BLK_W-1:0]             dir_rsp_data_i,
  input  logic [ADDR_W-1:0]            dir_rsp_addr_i,
  input  logic                         dir_rsp_excl_i,
  input  logic [CPU_W:0]               dir_rsp_ack_num_i,
  input  logic [N_CPU-1:0]             dir_rsp_requesters_i,
  input  logic                         dir_rsp_put_ack_i,
  input  logic                         dir_inv_valid_i,
  input  logic [N_CPU-1:0]             dir_inv_mask_i,
  input  logic [ADDR_W-1:0]            dir_inv_addr_i,
  output logic [N_CPU-1:0]             cpu_rsp_valid_o,
  output logic [4*N_CPU-1:0]           cpu_rsp_type_o,
  output logic [BLK_W*N_CPU-1:0]       cpu_rsp_data_o,
  output logic [ADDR_W*N_CPU-1:0]      cpu_rsp_addr_o,
  output logic [N_CPU-1:0]             cpu_rsp_excl_o,
  output logic [(CPU_W+1)*N_CPU-1:0]   cpu_rsp_ack_num_o,
  output logic [N_CPU*N_CPU-1:0]       cpu_rsp_requesters_o,
  output logic [N_CPU-1:0]             cpu_rsp_put_ack_o,
  output logic [N_CPU-1:0]             cpu_inv_en_o,
  output logic [ADDR_W-1:0]            cpu_inv_addr_o,
  output logic [(CPU_W+1)*N_CPU-1:0]   cpu_ack_cnt_o
);

  localparam int CNT_W = CPU_W + 1;

  logic                               dirReqValid_q;
  logic [3:0]                         dirReqType_q;
  logic [BLK_W-1:0]                   dirReqData_q;
  logic [ADDR_W-1:0]                  dirReqAddr_q;
  logic [CPU_W-1:0]                   dirReqSrc_q;
  logic [CPU_W-1:0]                   rr_q;
  logic [CPU_W-1:0]                   rr_d;

  logic [N_CPU-1:0]                   rspValid_q;
  logic [N_CPU-1:0][3:0]              rspType_q;
  logic [N_CPU-1:0][BLK_W-1:0]        rspData_q;
  logic [N_CPU-1:0][ADDR_W-1:0]       rspAddr_q;
  logic [N_CPU-1:0]                   rspExcl_q;
  logic [N_CPU-1:0][CNT_W-1:0]        rspAckNum_q;
  logic [N_CPU-1:0][N_CPU-1:0]        rspRequesters_q;
  logic [N_CPU-1:0]                   rspPutAck_q;
  logic [N_CPU-1:0]                   invEn_q;
  logic [ADDR_W-1:0]                  invAddr_q;
  logic [N_CPU-1:0][CNT_W-1:0]        ackCnt_q;
  logic [N_CPU-1:0][CNT_W-1:0]        ackCnt_d;

  logic [N_CPU-1:0]                   peerReq;
  logic [N_CPU-1:0]                   dirReq;
  logic [N_CPU-1:0]                   grantOh;
  logic [N_CPU-1:0]                   peerReady;
  logic                               grantFound;
  logic [CPU_W-1:0]                   grantIdx;
  logic [CPU_W-1:0]                   scanIdx;
  int                                 scanSum;
  logic                               sliceLoad;
  logic [N_CPU-1:0]                   rspDir;
  logic [N_CPU-1:0]                   peerHit;
  logic [N_CPU-1:0][CPU_W-1:0]        peerSrc;
  logic                               peerFound;

  // Round-robin scan of directory-class requesters, starting at the rr pointer.
  always_comb begin
    peerReq    = '0;
    dirReq     = '0;
    grantOh    = '0;
    grantFound = 1'b0;
    grantIdx   = '0;
    scanIdx    = '0;
    scanSum    = 0;
    for (int i = 0; i < N_CPU; i++) begin
      peerReq[i] = cpu_req_valid_i[i] &&
                   (cpu_req_type_i[4*i +: 4] == TYPE_FORWARD_DATA_PUT_E ||
                    cpu_req_type_i[4*i +: 4] == TYPE_FORWARD_DATA_PUT_M);
      dirReq[i]  = cpu_req_valid_i[i] && !peerReq[i];
    end
    for (int k = 0; k < N_CPU; k++) begin
      scanSum = int'(rr_q) + k;
      if (scanSum >= N_CPU) scanSum = scanSum - N_CPU;
      scanIdx = CPU_W'(scanSum);
      if (!grantFound && dirReq[scanIdx]) begin
        grantFound = 1'b1;
        grantIdx   = scanIdx;
      end
    end
    sliceLoad = grantFound && (!dirReqValid_q || dir_req_ready_i);
    if (sliceLoad) grantOh[grantIdx] = 1'b1;
    rr_d = (grantIdx == CPU_W'(N_CPU-1)) ? '0 : grantIdx + CPU_W'(1);
  end

  // Directory responses pre-empt peer forwards; among peers the lowest index wins a destination.
  always_comb begin
    rspDir    = '0;
    peerHit   = '0;
    peerSrc   = '0;
    peerReady = '0;
    peerFound = 1'b0;
    for (int d = 0; d < N_CPU; d++) begin
      rspDir[d] = dir_rsp_valid_i && (dir_rsp_dst_i == CPU_W'(d));
      peerFound = 1'b0;
      for (int i = 0; i < N_CPU; i++) begin
        if (!rspDir[d] && !peerFound && peerReq[i] && (i != d) &&
            cpu_req_dst_i[CPU_W*i +: CPU_W] == CPU_W'(d)) begin
          peerFound    = 1'b1;
          peerSrc[d]   = CPU_W'(i);
          peerReady[i] = 1'b1;
        end
      end
      peerHit[d] = peerFound;
    end
  end

  always_comb begin
    ackCnt_d = '0;
    for (int d = 0; d < N_CPU; d++) begin
      for (int i = 0; i < N_CPU; i++) begin
        if (cpu_inv_ack_i[i] && cpu_inv_ack_dst_i[CPU_W*i +: CPU_W] == CPU_W'(d))
          ackCnt_d[d] = ackCnt_d[d] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dirReqValid_q <= 1'b0;
      dirReqType_q  <= TYPE_NONE;
      dirReqData_q  <= '0;
      dirReqAddr_q  <= '0;
      dirReqSrc_q   <= '0;
      rr_q          <= '0;
    end else if (sliceLoad) begin
      dirReqValid_q <= 1'b1;
      dirReqType_q  <= cpu_req_type_i[4*int'(grantIdx) +: 4];
      dirReqData_q  <= cpu_req_data_i[BLK_W*int'(grantIdx) +: BLK_W];
      dirReqAddr_q  <= cpu_req_addr_i[ADDR_W*int'(grantIdx) +: ADDR_W];
      dirReqSrc_q   <= grantIdx;
      rr_q          <= rr_d;
    end else if (dir_req_ready_i) begin
      dirReqValid_q <= 1'b0;
    end
  end

  // Response fields hold their last value between pulses; only the valid bit pulses.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rspValid_q      <= '0;
      rspType_q       <= {N_CPU{TYPE_NONE}};
      rspData_q       <= '0;
      rspAddr_q       <= '0;
      rspExcl_q       <= '0;
      rspAckNum_q     <= '0;
      rspRequesters_q <= '0;
      rspPutAck_q     <= '0;
    end else begin
      for (int d = 0; d < N_CPU; d++) begin
        rspValid_q[d] <= rspDir[d] || peerHit[d];
        if (rspDir[d]) begin
          rspType_q[d]       <= dir_rsp_type_i;
          rspData_q[d]       <= dir_rsp_data_i;
          rspAddr_q[d]       <= dir_rsp_addr_i;
          rspExcl_q[d]       <= dir_rsp_excl_i;
          rspAckNum_q[d]     <= dir_rsp_ack_num_i;
          rspRequesters_q[d] <= dir_rsp_requesters_i;
          rspPutAck_q[d]     <= dir_rsp_put_ack_i;
        end else if (peerHit[d]) begin
          rspType_q[d]       <= TYPE_FORWARD_DATA;
          rspData_q[d]       <= cpu_req_data_i[BLK_W*int'(peerSrc[d]) +: BLK_W];
          rspAddr_q[d]       <= cpu_req_addr_i[ADDR_W*int'(peerSrc[d]) +: ADDR_W];
          rspExcl_q[d]       <= 1'b0;
          rspAckNum_q[d]     <= '0;
          rspRequesters_q[d] <= '0;
          rspPutAck_q[d]     <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      invEn_q   <= '0;
      invAddr_q <= '0;
      ackCnt_q  <= '0;
    end else begin
      invEn_q  <= dir_inv_valid_i ? dir_inv_mask_i : '0;
      ackCnt_q <= ackCnt_d;
      if (dir_inv_valid_i) invAddr_q <= dir_inv_addr_i;
    end
  end

  assign cpu_req_ready_o      = grantOh | peerReady;
  assign dir_req_valid_o      = dirReqValid_q;
  assign dir_req_type_o       = dirReqType_q;
  assign dir_req_data_o       = dirReqData_q;
  assign dir_req_addr_o       = dirReqAddr_q;
  assign dir_req_src_o        = dirReqSrc_q;
  assign cpu_rsp_valid_o      = rspValid_q;
  assign cpu_rsp_type_o       = rspType_q;
  assign cpu_rsp_data_o       = rspData_q;
  assign cpu_rsp_addr_o       = rspAddr_q;
  assign cpu_rsp_excl_o       = rspExcl_q;
  assign cpu_rsp_ack_num_o    = rspAckNum_q;
  assign cpu_rsp_requesters_o = rspRequesters_q;
  assign cpu_rsp_put_ack_o    = rspPutAck_q;
  assign cpu_inv_en_o         = invEn_q;
  assign cpu_inv_addr_o       = invAddr_q;
  assign cpu_ack_cnt_o        = ackCnt_q;

endmodule

// File: tb/tb_coherence_xbar_n.sv
// Directed bench for coherence_xbar_n (N_CPU=4): arbitration, backpressure, routing, invalidations, acks.
module tb_coherence_xbar_n;

  localparam logic [3:0] NONE      = 4'h0;
  localparam logic [3:0] GET_S     = 4'h1;
  localparam logic [3:0] GET_M     = 4'h2;
  localparam logic [3:0] FWD_PUT_E = 4'h6;
  localparam logic [3:0] FWD_PUT_M = 4'h7;
  localparam logic [3:0] FWD_DATA  = 4'h8;
  localparam logic [3:0] DIR_DATA  = 4'h9;

  logic         sys_clk;
  logic         sys_rst;
  logic [3:0]   cpu_req_valid;
  logic [3:0]   cpu_req_ready;
  logic [15:0]  cpu_req_type;
  logic [511:0] cpu_req_data;
  logic [127:0] cpu_req_addr;
  logic [7:0]   cpu_req_dst;
  logic [3:0]   cpu_inv_ack;
  logic [7:0]   cpu_inv_ack_dst;
  logic         dir_req_valid;
  logic         dir_req_ready;
  logic [3:0]   dir_req_type;
  logic [127:0] dir_req_data;
  logic [31:0]  dir_req_addr;
  logic [1:0]   dir_req_src;
  logic         dir_rsp_valid;
  logic [1:0]   dir_rsp_dst;
  logic [3:0]   dir_rsp_type;
  logic [127:0] dir_rsp_data;
  logic [31:0]  dir_rsp_addr;
  logic         dir_rsp_excl;
  logic [2:0]   dir_rsp_ack_num;
  logic [3:0]   dir_rsp_requesters;
  logic         dir_rsp_put_ack;
  logic         dir_inv_valid;
  logic [3:0]   dir_inv_mask;
  logic [31:0]  dir_inv_addr;
  logic [3:0]   cpu_rsp_valid;
  logic [15:0]  cpu_rsp_type;
  logic [511:0] cpu_rsp_data;
  logic [127:0] cpu_rsp_addr;
  logic [3:0]   cpu_rsp_excl;
  logic [11:0]  cpu_rsp_ack_num;
  logic [15:0]  cpu_rsp_requesters;
  logic [3:0]   cpu_rsp_put_ack;
  logic [3:0]   cpu_inv_en;
  logic [31:0]  cpu_inv_addr;
  logic [11:0]  cpu_ack_cnt;

  int errCount   = 0;
  int checkCount = 0;

  coherence_xbar_n dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cpu_req_valid_i(cpu_req_valid), .cpu_req_ready_o(cpu_req_ready),
    .cpu_req_type_i(cpu_req_type), .cpu_req_data_i(cpu_req_data),
    .cpu_req_addr_i(cpu_req_addr), .cpu_req_dst_i(cpu_req_dst),
    .cpu_inv_ack_i(cpu_inv_ack), .cpu_inv_ack_dst_i(cpu_inv_ack_dst),
    .dir_req_valid_o(dir_req_valid), .dir_req_ready_i(dir_req_ready),
    .dir_req_type_o(dir_req_type), .dir_req_data_o(dir_req_data),
    .dir_req_addr_o(dir_req_addr), .dir_req_src_o(dir_req_src),
    .dir_rsp_valid_i(dir_rsp_valid), .dir_rsp_dst_i(dir_rsp_dst),
    .dir_rsp_type_i(dir_rsp_type), .dir_rsp_data_i(dir_rsp_data),
    .dir_rsp_addr_i(dir_rsp_addr), .dir_rsp_excl_i(dir_rsp_excl),
    .dir_rsp_ack_num_i(dir_rsp_ack_num), .dir_rsp_requesters_i(dir_rsp_requesters),
    .dir_rsp_put_ack_i(dir_rsp_put_ack),
    .dir_inv_valid_i(dir_inv_valid), .dir_inv_mask_i(dir_inv_mask),
    .dir_inv_addr_i(dir_inv_addr),
    .cpu_rsp_valid_o(cpu_rsp_valid), .cpu_rsp_type_o(cpu_rsp_type),
    .cpu_rsp_data_o(cpu_rsp_data), .cpu_rsp_addr_o(cpu_rsp_addr),
    .cpu_rsp_excl_o(cpu_rsp_excl), .cpu_rsp_ack_num_o(cpu_rsp_ack_num),
    .cpu_rsp_requesters_o(cpu_rsp_requesters), .cpu_rsp_put_ack_o(cpu_rsp_put_ack),
    .cpu_inv_en_o(cpu_inv_en), .cpu_inv_addr_o(cpu_inv_addr),
    .cpu_ack_cnt_o(cpu_ack_cnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cpu, input logic valid, input logic [3:0] typ,
                               input logic [31:0] addr, input logic [127:0] data, input logic [1:0] dst);
    cpu_req_valid[cpu]       = valid;
    cpu_req_type[4*cpu +: 4] = typ;
    cpu_req_addr[32*cpu +: 32] = addr;
    cpu_req_data[128*cpu +: 128] = data;
    cpu_req_dst[2*cpu +: 2]  = dst;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst = 1'b1;
    cpu_req_valid = '0; cpu_req_type = '0; cpu_req_data = '0; cpu_req_addr = '0; cpu_req_dst = '0;
    cpu_inv_ack = '0; cpu_inv_ack_dst = '0; dir_req_ready = 1'b0;
    dir_rsp_valid = 1'b0; dir_rsp_dst = '0; dir_rsp_type = '0; dir_rsp_data = '0; dir_rsp_addr = '0;
    dir_rsp_excl = 1'b0; dir_rsp_ack_num = '0; dir_rsp_requesters = '0; dir_rsp_put_ack = 1'b0;
    dir_inv_valid = 1'b0; dir_inv_mask = '0; dir_inv_addr = '0;

    repeat (2) @(posedge sys_clk);
    #1;
    $display("[TB] reset checks");
    checkOutput("rst_dir_valid", dir_req_valid, 0);
    checkOutput("rst_dir_type", dir_req_type, NONE);
    checkOutput("rst_rsp_valid", cpu_rsp_valid, 0);
    checkOutput("rst_rsp_type", cpu_rsp_type, 0);
    checkOutput("rst_inv_en", cpu_inv_en, 0);
    checkOutput("rst_ack_cnt", cpu_ack_cnt, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    $display("[TB] round-robin arbitration");
    tick();
    dir_req_ready = 1'b1;
    applyStimulus(0, 1, GET_S, 32'h100, 128'hA0, 0);
    applyStimulus(2, 1, GET_M, 32'h200, 128'hA2, 0);
    #1 checkOutput("rr_ready_first", cpu_req_ready, 4'b0001);
    tick();
    checkOutput("rr_slice_src0", dir_req_src, 0);
    checkOutput("rr_slice_addr0", dir_req_addr, 32'h100);
    checkOutput("rr_slice_type0", dir_req_type, GET_S);
    checkOutput("rr_slice_data0", dir_req_data, 128'hA0);
    applyStimulus(0, 0, NONE, 0, 0, 0);
    #1 checkOutput("rr_ready_second", cpu_req_ready, 4'b0100);
    tick();
    checkOutput("rr_slice_src2", dir_req_src, 2);
    checkOutput("rr_slice_addr2", dir_req_addr, 32'h200);

    $display("[TB] backpressure");
    applyStimulus(2, 0, NONE, 0, 0, 0);
    dir_req_ready = 1'b0;
    applyStimulus(0, 1, GET_M, 32'h300, 128'hB0, 0);
    applyStimulus(3, 1, GET_S, 32'h400, 128'hB3, 0);
    #1 checkOutput("bp_ready_blocked", cpu_req_ready, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("bp_ready_held", cpu_req_ready, 0);
      checkOutput("bp_valid_held", dir_req_valid, 1);
      checkOutput("bp_src_held", dir_req_src, 2);
      checkOutput("bp_addr_held", dir_req_addr, 32'h200);
    end
    dir_req_ready = 1'b1;
    #1 checkOutput("rr_ptr_at_3", cpu_req_ready, 4'b1000);
    tick();
    checkOutput("rr_slice_src3", dir_req_src, 3);
    checkOutput("rr_slice_addr3", dir_req_addr, 32'h400);
    applyStimulus(3, 0, NONE, 0, 0, 0);
    #1 checkOutput("rr_wrap_to_0", cpu_req_ready, 4'b0001);
    tick();
    checkOutput("rr_slice_src0b", dir_req_src, 0);
    checkOutput("rr_slice_addr0b", dir_req_addr, 32'h300);
    applyStimulus(0, 0, NONE, 0, 0, 0);
    #1 checkOutput("idle_ready", cpu_req_ready, 0);
    tick();
    checkOutput("slice_drained", dir_req_valid, 0);

    $display("[TB] dir response beats peer forward");
    applyStimulus(1, 1, FWD_PUT_M, 32'h500, 128'hD1, 3);
    dir_rsp_valid = 1'b1; dir_rsp_dst = 3; dir_rsp_type = DIR_DATA; dir_rsp_data = 128'hDD;
    dir_rsp_addr = 32'h600; dir_rsp_excl = 1'b1; dir_rsp_ack_num = 3'd2; dir_rsp_requesters = 4'b0110;
    #1 checkOutput("peer_blocked_ready", cpu_req_ready, 0);
    tick();
    checkOutput("dirrsp_valid", cpu_rsp_valid, 4'b1000);
    checkOutput("dirrsp_type", cpu_rsp_type[15:12], DIR_DATA);
    checkOutput("dirrsp_data", cpu_rsp_data[511:384], 128'hDD);
    checkOutput("dirrsp_addr", cpu_rsp_addr[127:96], 32'h600);
    checkOutput("dirrsp_excl", cpu_rsp_excl[3], 1);
    checkOutput("dirrsp_acknum", cpu_rsp_ack_num[11:9], 2);
    checkOutput("dirrsp_reqs", cpu_rsp_requesters[15:12], 4'b0110);
    dir_rsp_valid = 1'b0;
    #1 checkOutput("peer_ready_after", cpu_req_ready, 4'b0010);
    tick();
    checkOutput("fwd3_valid", cpu_rsp_valid, 4'b1000);
    checkOutput("fwd3_type", cpu_rsp_type[15:12], FWD_DATA);
    checkOutput("fwd3_data", cpu_rsp_data[511:384], 128'hD1);
    checkOutput("fwd3_addr", cpu_rsp_addr[127:96], 32'h500);
    checkOutput("fwd3_excl", cpu_rsp_excl[3], 0);
    checkOutput("fwd3_acknum", cpu_rsp_ack_num[11:9], 0);
    checkOutput("fwd3_reqs", cpu_rsp_requesters[15:12], 0);
    applyStimulus(1, 0, NONE, 0, 0, 0);
    tick();
    checkOutput("rsp_pulse_end", cpu_rsp_valid, 0);

    $display("[TB] peer contention on one destination");
    applyStimulus(0, 1, FWD_PUT_E, 32'h700, 128'hE0, 1);
    applyStimulus(2, 1, FWD_PUT_E, 32'h720, 128'hE2, 1);
    #1 checkOutput("peer_low_wins", cpu_req_ready, 4'b0001);
    tick();
    checkOutput("fwd1a_valid", cpu_rsp_valid, 4'b0010);
    checkOutput("fwd1a_type", cpu_rsp_type[7:4], FWD_DATA);
    checkOutput("fwd1a_data", cpu_rsp_data[255:128], 128'hE0);
    checkOutput("fwd1a_excl", cpu_rsp_excl[1], 0);
    applyStimulus(0, 0, NONE, 0, 0, 0);
    #1 checkOutput("peer_second_ready", cpu_req_ready, 4'b0100);
    tick();
    checkOutput("fwd1b_valid", cpu_rsp_valid, 4'b0010);
    checkOutput("fwd1b_data", cpu_rsp_data[255:128], 128'hE2);
    checkOutput("fwd1b_addr", cpu_rsp_addr[63:32], 32'h720);
    applyStimulus(2, 1, FWD_PUT_E, 32'h740, 128'hE4, 2);
    #1 checkOutput("self_dst_ready", cpu_req_ready, 0);
    tick();
    checkOutput("self_dst_no_rsp", cpu_rsp_valid, 0);
    applyStimulus(2, 0, NONE, 0, 0, 0);

    $display("[TB] invalidation multicast");
    dir_inv_valid = 1'b1; dir_inv_mask = 4'b1011; dir_inv_addr = 32'h40;
    tick();
    checkOutput("inv_en", cpu_inv_en, 4'b1011);
    checkOutput("inv_addr", cpu_inv_addr, 32'h40);
    dir_inv_valid = 1'b0; dir_inv_addr = 32'h99;
    tick();
    checkOutput("inv_en_pulse_end", cpu_inv_en, 0);
    checkOutput("inv_addr_held", cpu_inv_addr, 32'h40);
    dir_inv_valid = 1'b1; dir_inv_mask = 4'b0000; dir_inv_addr = 32'h80;
    tick();
    checkOutput("inv_mask0_en", cpu_inv_en, 0);
    checkOutput("inv_mask0_addr", cpu_inv_addr, 32'h80);
    dir_inv_valid = 1'b0;

    $display("[TB] ack counting");
    cpu_inv_ack = 4'b1110; cpu_inv_ack_dst = 8'b00_00_00_00;
    tick();
    checkOutput("ack_three_to0", cpu_ack_cnt, 12'h003);
    cpu_inv_ack = 4'b1011; cpu_inv_ack_dst = {2'd2, 2'd0, 2'd1, 2'd2};
    tick();
    checkOutput("ack_mixed", cpu_ack_cnt, 12'h088);
    cpu_inv_ack = 4'b0000;
    tick();
    checkOutput("ack_zero", cpu_ack_cnt, 0);

    $display("[TB] reset mid-operation");
    dir_req_ready = 1'b0;
    applyStimulus(1, 1, GET_S, 32'h800, 128'hC1, 0);
    tick();
    checkOutput("mid_slice_loaded", dir_req_valid, 1);
    checkOutput("mid_slice_src", dir_req_src, 1);
    #2 sys_rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", dir_req_valid, 0);
    checkOutput("mid_rst_type", dir_req_type, NONE);
    checkOutput("mid_rst_src", dir_req_src, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    applyStimulus(1, 0, NONE, 0, 0, 0);
    applyStimulus(0, 1, GET_S, 32'h900, 128'hC0, 0);
    applyStimulus(3, 1, GET_S, 32'h910, 128'hC3, 0);
    #1 checkOutput("rr_reset_to0", cpu_req_ready, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
